clock_mode_sched: RTL and testbench
===================================

Name: clock_mode_sched

Overview:
- Mode controller and increment scheduler for the BCD wall-clock datapath: seconds, minutes and the hours counter with 00-23 wrap.
- Decides each cycle which counter receives an increment pulse: normal timekeeping carry chain driven by a 1 Hz tick, or user set-mode driven by debounced push buttons.
- Drives seconds clear, set-mode blink and a set-mode indicator.
- Sits between the prescaler/button pads and the three counter blocks.

Parameters:
- DB_CYCLES, 8000, clk cycles a synchronized button level must be stable before it is accepted.
- TIMEOUT_TICKS, 30, 1 Hz ticks with no accepted button press before set mode auto-exits to RUN.
- HOLD_CYCLES, 16000, clk cycles btn_inc must be held before auto-repeat starts (used only with the optional feature).
- REPEAT_CYCLES, 4000, clk cycles between auto-repeat pulses (used only with the optional feature).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- tick_1hz  input  1  single-cycle 1 Hz enable pulse, synchronous to clk
- btn_mode  input  1  raw mode push button, active-high, asynchronous
- btn_inc  input  1  raw increment push button, active-high, asynchronous
- sec_max  input  1  seconds counter currently at 59
- min_max  input  1  minutes counter currently at 59
- sec_inc  output  1  one-cycle increment pulse to seconds counter
- min_inc  output  1  one-cycle increment pulse to minutes counter
- hr_inc  output  1  one-cycle increment pulse to hours counter
- sec_clr  output  1  one-cycle clear pulse to seconds counter
- blink  output  1  display blink for the field being set
- set_active  output  1  high in any set state
- state  output  2  current state: 0 RUN, 1 SET_HR, 2 SET_MIN

Behaviour:
- Reset (async, rst=1): state=RUN. All pulse outputs 0, blink=0, set_active=0. Debounce, timeout and repeat counters 0. Debounced levels 0.
- All outputs are registered.
- Button path, per button:
  - 2-flop synchronizer.
  - Stability counter; debounced level takes the synchronized value after DB_CYCLES consecutive equal samples. Any change restarts the count.
  - Rising edge of the debounced level gives a one-cycle press event, accepted in cycle N.
- State machine, transitions taken at the edge following the press event (N+1):
  - RUN, mode press: to SET_HR.
  - SET_HR, mode press: to SET_MIN.
  - SET_MIN, mode press: to RUN, with sec_clr=1 for one cycle at the same edge.
  - Timeout in SET_HR or SET_MIN: to RUN with sec_clr pulse.
- RUN scheduling, on a tick_1hz cycle (outputs registered one cycle after the tick):
  - sec_inc=1 always.
  - min_inc=1 when sec_max=1.
  - hr_inc=1 when sec_max=1 and min_max=1.
  - sec_max/min_max are sampled in the tick cycle. Carries are concurrent, not rippled over cycles.
- Set states:
  - Inc press: hr_inc (SET_HR) or min_inc (SET_MIN) for one cycle. sec_inc is never asserted.
  - tick_1hz does not advance time; counters are paused.
- Simultaneous mode and inc press in the same cycle: mode wins, inc is discarded.
- Timeout counter:
  - Counts ticks in set states.
  - Cleared by any accepted press and on entry to a set state.
  - Reaching TIMEOUT_TICKS forces the exit to RUN.
- blink:
  - 0 in RUN.
  - In set states, toggles on each tick_1hz.
  - Forced to 1 for the cycle following an inc press, then continues toggling from 1.
- set_active = (state != RUN).
- Exactly one of min_inc/hr_inc can pulse from set mode per cycle. No pulse is ever longer than one cycle.
- rst mid-operation: immediate return to RUN. Pending press events and the repeat timer are dropped.

Optional Feature:
- AUTO_REPEAT_EN defined, in a set state:
  - Holding btn_inc debounced-high for HOLD_CYCLES after the press produces an additional inc pulse, then another every REPEAT_CYCLES while held.
  - Each repeat pulse clears the timeout counter.
  - Release, a mode press or leaving the set state stops repetition.
- AUTO_REPEAT_EN undefined: only one pulse per press; the repeat counters are absent.

Test Plan:
- Reset with rst=1 mid-count, then release -> state=0, all pulses 0, blink=0; first tick gives a sec_inc pulse only.
- RUN, tick with sec_max=1, min_max=0 -> sec_inc=min_inc=1, hr_inc=0 for exactly one cycle; with both max=1 -> all three pulse together.
- btn_inc glitch shorter than DB_CYCLES (DB_CYCLES=4 in sim) -> no pulse. mode held 6 cycles -> state 0->1 once, no repeat on continued hold.
- SET_HR: 3 inc presses -> 3 hr_inc pulses, no sec_inc despite ticks. Mode -> SET_MIN; 2 presses -> 2 min_inc. Mode -> RUN with a sec_clr pulse.
- SET_MIN with no presses for TIMEOUT_TICKS=3 ticks -> state=0 and a sec_clr pulse after the 3rd tick. Mode and inc pressed in the same cycle -> state advances, no inc pulse.
- AUTO_REPEAT_EN with HOLD=10, REPEAT=5, inc held 30 cycles in SET_HR -> hr_inc at press, then at +10, +15, +20, +25, +30 cycles while held. Release -> no further pulses.

Source files
------------

// File: rtl/clock_mode_sched.sv
// clock_mode_sched: mode controller and increment scheduler for the BCD
// wall clock (seconds / minutes / 00-23 hours counters).
//
// Optional build macro: AUTO_REPEAT_EN adds auto-repeat of btn_inc while it
// is held in a set state (HOLD_CYCLES to the first repeat, REPEAT_CYCLES
// between repeats). Without the macro each press gives exactly one pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal timekeeping, 1 Hz tick drives the carry chain
// SET_HR  | user sets hours, btn_inc pulses hr_inc, time paused
// SET_MIN | user sets minutes, btn_inc pulses min_inc, time paused

module clock_mode_sched #(
   parameter int DB_CYCLES     = 8000,
   parameter int TIMEOUT_TICKS = 30,
   parameter int HOLD_CYCLES   = 16000,
   parameter int REPEAT_CYCLES = 4000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       sec_max,
   input  logic       min_max,
   output logic       sec_inc,
   output logic       min_inc,
   output logic       hr_inc,
   output logic       sec_clr,
   output logic       blink,
   output logic       set_active,
   output logic [1:0] state
);

   if (DB_CYCLES < 1 || TIMEOUT_TICKS < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
      $error("clock_mode_sched: timing parameters must all be >= 1");
   end

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2
   } state_t;

   localparam int DB_W  = $clog2(DB_CYCLES) + 1;
   localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [DB_W-1:0]  DB_LOAD  = DB_W'(DB_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_TICKS);

   // index 0 = mode button, index 1 = inc button
   logic [1:0]      sync1, sync2, db, db_q;
   logic [DB_W-1:0] db_cnt [2];
   logic            mode_press, inc_press;

   state_t          cur_st, nxt_st;
   logic [TMO_W-1:0] tmo_cnt;
   logic            timeout;
   logic            rpt_evt;
   logic            set_inc;

   logic sec_inc_d, min_inc_d, hr_inc_d, sec_clr_d, blink_d, set_active_d;

   // Synchronize both buttons and accept a level only after DB_CYCLES equal samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1     <= '0;
         sync2     <= '0;
         db        <= '0;
         db_q      <= '0;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         sync1 <= {btn_inc, btn_mode};
         sync2 <= sync1;
         db_q  <= db;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == db[i]) begin
               db_cnt[i] <= DB_LOAD;
            end else if (db_cnt[i] == '0) begin
               db[i]     <= sync2[i];
               db_cnt[i] <= DB_LOAD;
            end else begin
               db_cnt[i] <= db_cnt[i] - DB_W'(1);
            end
         end
      end
   end

   assign mode_press = db[0] & ~db_q[0];
   assign inc_press  = db[1] & ~db_q[1];

   // A press on the same tick as the last timeout tick keeps set mode alive
   assign timeout = (cur_st != RUN) && tick_1hz && (tmo_cnt == TMO_W'(1)) &&
                    !mode_press && !inc_press && !rpt_evt;

`ifdef AUTO_REPEAT_EN
   localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int RPT_W   = $clog2(RPT_MAX) + 1;

   logic             rpt_armed;
   logic [RPT_W-1:0] rpt_cnt;

   assign rpt_evt = rpt_armed && db[1] && (rpt_cnt == '0) && !mode_press && (cur_st != RUN);

   // Hold timer armed by an inc press; any release, mode press or state change disarms it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rpt_armed <= 1'b0;
         rpt_cnt   <= '0;
      end else if (cur_st == RUN || mode_press || !db[1] || nxt_st != cur_st) begin
         rpt_armed <= 1'b0;
         rpt_cnt   <= '0;
      end else if (inc_press) begin
         rpt_armed <= 1'b1;
         rpt_cnt   <= RPT_W'(HOLD_CYCLES - 1);
      end else if (rpt_armed) begin
         if (rpt_cnt == '0) rpt_cnt <= RPT_W'(REPEAT_CYCLES - 1);
         else               rpt_cnt <= rpt_cnt - RPT_W'(1);
      end
   end
`else
   assign rpt_evt = 1'b0;
`endif

   // Mode wins over inc when both are accepted in the same cycle
   assign set_inc = (inc_press && !mode_press) || rpt_evt;

   // Set-mode inactivity timer: reloads on entry and on every accepted press
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if (nxt_st == RUN) begin
         tmo_cnt <= '0;
      end else if (nxt_st != cur_st || mode_press || inc_press || rpt_evt) begin
         tmo_cnt <= TMO_LOAD;
      end else if (tick_1hz && tmo_cnt != '0) begin
         tmo_cnt <= tmo_cnt - TMO_W'(1);
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cur_st <= RUN;
      else     cur_st <= nxt_st;
   end

   // Next-state decode
   always_comb begin
      nxt_st = cur_st;
      case (cur_st)
         RUN:     if (mode_press)            nxt_st = SET_HR;
         SET_HR:  if (mode_press)            nxt_st = SET_MIN;
                  else if (timeout)          nxt_st = RUN;
         SET_MIN: if (mode_press || timeout) nxt_st = RUN;
         default:                            nxt_st = RUN;
      endcase
   end

   // Output decode; carries in RUN are all resolved from the tick-cycle max flags
   always_comb begin
      sec_inc_d    = 1'b0;
      min_inc_d    = 1'b0;
      hr_inc_d     = 1'b0;
      sec_clr_d    = 1'b0;
      set_active_d = (nxt_st != RUN);
      case (cur_st)
         RUN: begin
            if (tick_1hz) begin
               sec_inc_d = 1'b1;
               min_inc_d = sec_max;
               hr_inc_d  = sec_max & min_max;
            end
         end
         SET_HR: begin
            hr_inc_d  = set_inc;
            sec_clr_d = timeout;
         end
         SET_MIN: begin
            min_inc_d = set_inc;
            sec_clr_d = mode_press || timeout;
         end
         default: ;
      endcase
      if (nxt_st == RUN)                         blink_d = 1'b0;
      else if (cur_st != RUN && set_inc)         blink_d = 1'b1;
      else if (cur_st != RUN && tick_1hz)        blink_d = ~blink;
      else                                       blink_d = blink;
   end

   // Registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sec_inc    <= 1'b0;
         min_inc    <= 1'b0;
         hr_inc     <= 1'b0;
         sec_clr    <= 1'b0;
         blink      <= 1'b0;
         set_active <= 1'b0;
      end else begin
         sec_inc    <= sec_inc_d;
         min_inc    <= min_inc_d;
         hr_inc     <= hr_inc_d;
         sec_clr    <= sec_clr_d;
         blink      <= blink_d;
         set_active <= set_active_d;
      end
   end

   assign state = cur_st;

endmodule

// File: tb/tb_clock_mode_sched.sv
// Scoreboard bench for clock_mode_sched with short debounce/timeout values.
// Stimulus pushes the expected pulse pattern; a monitor thread pops and
// compares whenever any pulse output is high.

module tb_clock_mode_sched;

   localparam int DB   = 4;
   localparam int TMO  = 3;
   localparam int HOLD = 10;
   localparam int RPT  = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_1hz = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic       sec_max = 1'b0;
   logic       min_max = 1'b0;
   logic       sec_inc, min_inc, hr_inc, sec_clr, blink, set_active;
   logic [1:0] state;

   clock_mode_sched #(
      .DB_CYCLES(DB), .TIMEOUT_TICKS(TMO), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT)
   ) dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .sec_max(sec_max), .min_max(min_max), .sec_inc(sec_inc), .min_inc(min_inc),
      .hr_inc(hr_inc), .sec_clr(sec_clr), .blink(blink), .set_active(set_active),
      .state(state)
   );

   always #5 clk = ~clk;

   // {sec_inc, min_inc, hr_inc, sec_clr, state}
   typedef struct packed {
      logic       s;
      logic       m;
      logic       h;
      logic       c;
      logic [1:0] st;
   } exp_t;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic push(input logic s, input logic m, input logic h, input logic c, input logic [1:0] st);
      exp_t e;
      e.s = s; e.m = m; e.h = h; e.c = c; e.st = st;
      sb_q.push_back(e);
   endtask

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_tick(input logic smax, input logic mmax);
      sec_max  = smax;
      min_max  = mmax;
      tick_1hz = 1'b1;
      cyc(1);
      tick_1hz = 1'b0;
      sec_max  = 1'b0;
      min_max  = 1'b0;
      cyc(3);
   endtask

   // Held 6 cycles: long enough to debounce, then released and allowed to settle
   task automatic press(input logic m, input logic i);
      btn_mode = m;
      btn_inc  = i;
      cyc(6);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      cyc(10);
   endtask

   initial begin
      fork
         forever begin
            exp_t got;
            exp_t e;
            @(negedge clk);
            if (!rst && (sec_inc || min_inc || hr_inc || sec_clr)) begin
               got = {sec_inc, min_inc, hr_inc, sec_clr, state};
               tests++;
               if (sb_q.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_pulse: got %b expected no pulse", got);
               end else begin
                  e = sb_q.pop_front();
                  if (got !== e) begin
                     fails++;
                     $display("FAIL pulse: got %b expected %b", got, e);
                  end
               end
            end
         end
      join_none

      // reset held while a tick with carries is presented
      tick_1hz = 1'b1;
      sec_max  = 1'b1;
      cyc(2);
      check("rst_state", int'(state), 0);
      check("rst_pulses", int'({sec_inc, min_inc, hr_inc, sec_clr}), 0);
      check("rst_blink", int'(blink), 0);
      check("rst_set_active", int'(set_active), 0);
      tick_1hz = 1'b0;
      sec_max  = 1'b0;
      rst      = 1'b0;
      cyc(3);

      // RUN carry chain
      push(1, 0, 0, 0, 0); do_tick(0, 0);
      push(1, 1, 0, 0, 0); do_tick(1, 0);
      push(1, 0, 0, 0, 0); do_tick(0, 1);
      push(1, 1, 1, 0, 0); do_tick(1, 1);

      // inc in RUN does nothing
      press(0, 1);
      check("run_inc_state", int'(state), 0);

      // mode -> SET_HR, single transition despite 6-cycle hold
      press(1, 0);
      check("set_hr_state", int'(state), 1);
      check("set_hr_active", int'(set_active), 1);
      check("set_hr_blink0", int'(blink), 0);

      // glitch shorter than the debounce window
      btn_inc = 1'b1;
      cyc(3);
      btn_inc = 1'b0;
      cyc(10);

      // three hour increments, ticks do not advance time
      push(0, 0, 1, 0, 1); press(0, 1);
      check("blink_after_inc", int'(blink), 1);
      do_tick(0, 0);
      check("blink_toggle", int'(blink), 0);
      push(0, 0, 1, 0, 1); press(0, 1);
      do_tick(1, 1);
      push(0, 0, 1, 0, 1); press(0, 1);
      check("blink_after_inc3", int'(blink), 1);

      // SET_MIN, two minute increments, exit with seconds clear
      press(1, 0);
      check("set_min_state", int'(state), 2);
      push(0, 1, 0, 0, 2); press(0, 1);
      push(0, 1, 0, 0, 2); press(0, 1);
      push(0, 0, 0, 1, 0); press(1, 0);
      check("exit_state", int'(state), 0);
      check("exit_blink", int'(blink), 0);
      check("exit_active", int'(set_active), 0);

      // timeout after TMO ticks in SET_MIN
      press(1, 0);
      press(1, 0);
      do_tick(0, 0);
      do_tick(0, 0);
      check("tmo_not_yet", int'(state), 2);
      push(0, 0, 0, 1, 0); do_tick(0, 0);
      check("tmo_state", int'(state), 0);

      // mode and inc together: mode wins
      press(1, 0);
      press(1, 1);
      check("simul_state", int'(state), 2);
      push(0, 0, 0, 1, 0); press(1, 0);

`ifdef AUTO_REPEAT_EN
      // held inc: press pulse then +10, +15, +20, +25, +30
      press(1, 0);
      repeat (6) push(0, 0, 1, 0, 1);
      btn_inc = 1'b1;
      cyc(33);
      btn_inc = 1'b0;
      cyc(20);
      check("rpt_drain", sb_q.size(), 0);
      press(1, 0);
      push(0, 0, 0, 1, 0); press(1, 0);
`endif

      // reset mid-operation with an inc press still debouncing
      press(1, 0);
      check("pre_rst_state", int'(state), 1);
      btn_inc = 1'b1;
      cyc(2);
      rst = 1'b1;
      #1;
      check("async_rst_state", int'(state), 0);
      check("async_rst_active", int'(set_active), 0);
      cyc(2);
      btn_inc = 1'b0;
      rst     = 1'b0;
      cyc(10);
      check("post_rst_state", int'(state), 0);
      push(1, 0, 0, 0, 0); do_tick(0, 0);

      cyc(20);
      check("sb_drain", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
